// File: rtl/mem_arb_pkg.sv
// Shared types and counter widths for the memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } arb_owner_t;

   // Streak counter holds up to 15, timeout counter up to 255.
   localparam int STREAK_W = 4;
   localparam int TMO_W    = 8;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises the I-side (read only) and D-side (read/write)
// requesters onto one single-ported memory with enable-pulse / ack handshake,
// routes the ack and read data back to the owner and aborts accesses whose
// ack never arrives.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int D_STREAK_MAX = 4,
   parameter int TIMEOUT      = 15
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  IReq,
   input  logic [ADDR_WIDTH-1:0] IAddr,
   output logic                  IAck,
   output logic [DATA_WIDTH-1:0] IRdata,
   input  logic                  DReq,
   input  logic                  DWe,
   input  logic [ADDR_WIDTH-1:0] DAddr,
   input  logic [DATA_WIDTH-1:0] DWdata,
   output logic                  DAck,
   output logic [DATA_WIDTH-1:0] DRdata,
   output logic [ADDR_WIDTH-1:0] MemAddr,
   output logic                  MemRe,
   output logic                  MemWe,
   output logic [DATA_WIDTH-1:0] MemWdata,
   input  logic                  MemAck,
   input  logic [DATA_WIDTH-1:0] MemRdata,
   output logic                  Busy,
   output logic                  TimeoutErr
);

   localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(D_STREAK_MAX);
   localparam logic [TMO_W-1:0]    TMO_LIM    = TMO_W'(TIMEOUT);

   arb_state_t            state_q,  state_d;
   arb_owner_t            owner_q,  owner_d;
   logic                  op_we_q,  op_we_d;
   logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
   logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
   logic                  re_q,     re_d;
   logic                  we_q,     we_d;
   logic [STREAK_W-1:0]   streak_q, streak_d;
   logic [TMO_W-1:0]      tmo_q,    tmo_d;
   logic                  err_q,    err_d;

   logic grant_i;
   logic ack_ok;

   // I wins when D is not asking, or when D has used up its streak while I waits.
   assign grant_i = IReq && (!DReq || (streak_q == STREAK_LIM));

   // A memory ack only counts while an access is actually outstanding.
   assign ack_ok = MemAck && (state_q == WAIT);

   assign IAck       = ack_ok && (owner_q == OWN_I);
   assign DAck       = ack_ok && (owner_q == OWN_D);
   assign IRdata     = IAck ? MemRdata : '0;
   assign DRdata     = (DAck && !op_we_q) ? MemRdata : '0;
   assign MemAddr    = addr_q;
   assign MemWdata   = wdata_q;
   assign MemRe      = re_q;
   assign MemWe      = we_q;
   assign Busy       = (state_q != IDLE);
   assign TimeoutErr = err_q;

   // Next-state logic: grant in IDLE, one enable pulse in ISSUE, ack/timeout in WAIT.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      op_we_d  = op_we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      re_d     = 1'b0;
      we_d     = 1'b0;
      streak_d = streak_q;
      tmo_d    = tmo_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (IReq || DReq) begin
               state_d = ISSUE;
               if (grant_i) begin
                  owner_d  = OWN_I;
                  op_we_d  = 1'b0;
                  addr_d   = IAddr;
                  wdata_d  = '0;
                  re_d     = 1'b1;
                  streak_d = '0;
               end else begin
                  owner_d = OWN_D;
                  op_we_d = DWe;
                  addr_d  = DAddr;
                  wdata_d = DWdata;
                  re_d    = !DWe;
                  we_d    = DWe;
                  if (!IReq)
                     streak_d = '0;
                  else if (streak_q != STREAK_LIM)
                     streak_d = streak_q + STREAK_W'(1);
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
            tmo_d   = TMO_W'(1);
         end
         WAIT: begin
            if (MemAck) begin
               state_d = IDLE;
               tmo_d   = '0;
            end else if (tmo_q == TMO_LIM) begin
               state_d = IDLE;
               tmo_d   = '0;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            tmo_d   = '0;
         end
      endcase
   end

   // State and registered outputs; reset drops any access in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         owner_q  <= OWN_I;
         op_we_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         re_q     <= 1'b0;
         we_q     <= 1'b0;
         streak_q <= '0;
         tmo_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         op_we_q  <= op_we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         re_q     <= re_d;
         we_q     <= we_d;
         streak_q <= streak_d;
         tmo_q    <= tmo_d;
         err_q    <= err_d;
      end
   end

endmodule
